icacop_unit: RTL and testbench

// - ICache-side responder for CACOP ops targeting the ICache (code[1:0]==0), issued by the memory stage.
// - Accepts one op per valid/ready handshake. Clears ICache tag-array entries by index (modes 0/1)
//   or by physical-address hit (mode 2, via one MMU translation).
// - Returns a response that stays valid until consumed by writeback. While non-idle, busy_o stalls ICache fetch/refill.

---
 rtl/icacop_if.sv | 26 ++
 rtl/icacop_unit.sv | 158 +++++++++++++++
 tb/tb_icacop_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icacop_if.sv
// Request/response channel between the memory stage, writeback and the ICache CACOP responder.
interface icacop_if #(
  parameter int unsigned ROB_IDX_W = 6
) ();
  logic                 req_valid_i;
  logic [31:0]          req_vaddr_i;
  logic [ROB_IDX_W-1:0] req_rob_idx_i;
  logic [1:0]           req_mode_i;
  logic                 req_ready_o;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [ROB_IDX_W-1:0] rsp_rob_idx_o;
  logic [31:0]          rsp_vaddr_o;
  logic                 rsp_excp_o;
  logic [5:0]           rsp_ecode_o;

  modport master (
    output req_valid_i, req_vaddr_i, req_rob_idx_i, req_mode_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o, rsp_ecode_o
  );

  modport slave (
    input  req_valid_i, req_vaddr_i, req_rob_idx_i, req_mode_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o, rsp_ecode_o
  );
endinterface

// File: rtl/icacop_unit.sv
// ICache CACOP responder: invalidates tag entries by index (modes 0/1) or by physical hit (mode 2).
// Optional ICACOP_PERF_EN adds perf_cnt_o, counting non-faulting completed ops.
module icacop_unit #(
  parameter  int unsigned WAYS      = 2,
  parameter  int unsigned IDX_W     = 8,
  parameter  int unsigned OFFSET_W  = 4,
  parameter  int unsigned ROB_IDX_W = 6,
  localparam int unsigned TAG_W     = 32 - IDX_W - OFFSET_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  icacop_if.slave                   bus,
  input  logic                      flush_i,
  input  logic                      fetch_busy_i,
  output logic                      busy_o,
  output logic                      trans_req_o,
  output logic [31:0]               trans_vaddr_o,
  input  logic [31:0]               trans_paddr_i,
  input  logic                      trans_excp_i,
  input  logic [5:0]                trans_ecode_i,
  output logic                      tag_rd_o,
  output logic [WAYS-1:0]           tag_we_o,
  output logic [IDX_W-1:0]          tag_idx_o,
  output logic [TAG_W:0]            tag_wdata_o,
  input  logic [WAYS*(TAG_W+1)-1:0] tag_rdata_i
`ifdef ICACOP_PERF_EN
  ,
  output logic [31:0]               perf_cnt_o
`endif
);

  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_FETCH, TRANS, LOOKUP, WRITE, RESP
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          vaddr_q;
  logic [ROB_IDX_W-1:0] rob_q;
  logic [1:0]           mode_q;
  logic [TAG_W-1:0]     paddr_tag_q;
  logic                 excp_q;
  logic [5:0]           ecode_q;
  logic                 accept;
  logic [WAYS-1:0]      way_hit;
  logic [WAYS-1:0]      way_oh;
  logic [TAG_W:0]       entry;
  logic                 unused_paddr;

  assign unused_paddr = ^trans_paddr_i[OFFSET_W+IDX_W-1:0];
  assign accept       = (state_q == IDLE) && bus.req_valid_i && !flush_i;

  function automatic state_e dispatch(input logic [1:0] mode);
    case (mode)
      2'd2:    return TRANS;
      2'd3:    return RESP;
      default: return WRITE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.req_valid_i) state_d = fetch_busy_i ? WAIT_FETCH : dispatch(bus.req_mode_i);
      WAIT_FETCH: if (!fetch_busy_i) state_d = dispatch(mode_q);
      TRANS:      state_d = LOOKUP;
      LOOKUP:     state_d = trans_excp_i ? RESP : WRITE;
      WRITE:      state_d = RESP;
      RESP:       if (bus.rsp_ready_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    // Flush wins over everything, including a request arriving in the same cycle.
    if (flush_i) state_d = IDLE;
  end

  // Captured request and translation result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr_q     <= '0;
      rob_q       <= '0;
      mode_q      <= '0;
      paddr_tag_q <= '0;
      excp_q      <= 1'b0;
      ecode_q     <= '0;
    end else if (accept) begin
      vaddr_q     <= bus.req_vaddr_i;
      rob_q       <= bus.req_rob_idx_i;
      mode_q      <= bus.req_mode_i;
      paddr_tag_q <= '0;
      excp_q      <= 1'b0;
      ecode_q     <= '0;
    end else if (state_q == LOOKUP && !flush_i) begin
      paddr_tag_q <= trans_paddr_i[31 -: TAG_W];
      excp_q      <= trans_excp_i;
      ecode_q     <= trans_excp_i ? trans_ecode_i : 6'd0;
    end
  end

  always_comb begin
    way_hit = '0;
    entry   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      entry      = tag_rdata_i[w*(TAG_W+1) +: (TAG_W+1)];
      way_hit[w] = entry[TAG_W] && (entry[TAG_W-1:0] == paddr_tag_q);
    end
  end

  assign way_oh = WAYS'(1) << vaddr_q[WAY_W-1:0];

  always_comb begin
    bus.req_ready_o   = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.rsp_rob_idx_o = rob_q;
    bus.rsp_vaddr_o   = vaddr_q;
    bus.rsp_excp_o    = excp_q;
    bus.rsp_ecode_o   = ecode_q;
    busy_o            = 1'b1;
    trans_req_o       = 1'b0;
    trans_vaddr_o     = '0;
    tag_rd_o          = 1'b0;
    tag_we_o          = '0;
    tag_idx_o         = vaddr_q[OFFSET_W +: IDX_W];
    tag_wdata_o       = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        busy_o          = 1'b0;
        tag_idx_o       = '0;
      end
      TRANS: begin
        trans_req_o   = 1'b1;
        trans_vaddr_o = vaddr_q;
      end
      LOOKUP:  tag_rd_o = !trans_excp_i && !flush_i;
      WRITE:   if (!flush_i) tag_we_o = (mode_q == 2'd2) ? way_hit : way_oh;
      RESP:    bus.rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

`ifdef ICACOP_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               perf_q <= '0;
    else if (state_q == RESP && bus.rsp_ready_i && !excp_q)   perf_q <= perf_q + 32'd1;
  end

  assign perf_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_icacop_unit.sv
// Scoreboard bench for icacop_unit: expected responses queued at accept, popped when rsp_valid_o is seen.
module tb_icacop_unit;

  localparam int unsigned WAYS = 2, IDX_W = 8, OFFSET_W = 4, ROB_IDX_W = 6;
  localparam int unsigned TAG_W = 32 - IDX_W - OFFSET_W;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [31:0]          vaddr;
    logic                 excp;
    logic [5:0]           ecode;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic flush_i = 1'b0, fetch_busy_i = 1'b0, busy_o;
  logic trans_req_o, trans_excp_i = 1'b0, tag_rd_o;
  logic [31:0] trans_vaddr_o, trans_paddr_i = '0;
  logic [5:0] trans_ecode_i = '0;
  logic [WAYS-1:0] tag_we_o;
  logic [IDX_W-1:0] tag_idx_o;
  logic [TAG_W:0] tag_wdata_o;
  logic [WAYS*(TAG_W+1)-1:0] tag_rdata_i = '0;
`ifdef ICACOP_PERF_EN
  logic [31:0] perf_cnt_o;
`endif

  int total = 0, bad = 0;
  exp_t sb[$];
  exp_t e;

  icacop_if #(.ROB_IDX_W(ROB_IDX_W)) bus ();

  icacop_unit #(.WAYS(WAYS), .IDX_W(IDX_W), .OFFSET_W(OFFSET_W), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush_i(flush_i), .fetch_busy_i(fetch_busy_i),
    .busy_o(busy_o), .trans_req_o(trans_req_o), .trans_vaddr_o(trans_vaddr_o),
    .trans_paddr_i(trans_paddr_i), .trans_excp_i(trans_excp_i), .trans_ecode_i(trans_ecode_i),
    .tag_rd_o(tag_rd_o), .tag_we_o(tag_we_o), .tag_idx_o(tag_idx_o), .tag_wdata_o(tag_wdata_o),
    .tag_rdata_i(tag_rdata_i)
`ifdef ICACOP_PERF_EN
    , .perf_cnt_o(perf_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic [1:0] mode, input logic [31:0] va, input logic [5:0] rob);
    bus.req_valid_i   = 1'b1;
    bus.req_mode_i    = mode;
    bus.req_vaddr_i   = va;
    bus.req_rob_idx_i = rob;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
    bus.req_vaddr_i = '0; bus.req_rob_idx_i = '0; bus.req_mode_i = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.req_ready_o, bus.rsp_valid_o, busy_o, trans_req_o, tag_rd_o, tag_we_o, tag_idx_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00}) begin
      bad++; $display("FAIL reset_outputs: ready=%b rsp_valid=%b busy=%b treq=%b trd=%b twe=%b idx=%h", bus.req_ready_o, bus.rsp_valid_o, busy_o, trans_req_o, tag_rd_o, tag_we_o, tag_idx_o);
    end
    total++;
    if ({bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, tag_wdata_o} !== '0) begin
      bad++; $display("FAIL reset_fields: rob=%h va=%h excp=%b ecode=%h wdata=%h, want all 0", bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, tag_wdata_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Mode 0/1 ops issued back to back: fixed cases first, then random addresses.
  task automatic test_back_to_back();
    logic [31:0] va; logic [1:0] mode; logic [5:0] rob; logic [1:0] we_exp;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin va = 32'h0000_1235; mode = 2'd1; rob = 6'd5; end
      else if (i == 1) begin va = 32'h0000_ABC4; mode = 2'd0; rob = 6'd17; end
      else             begin va = $urandom; mode = 2'($urandom_range(0, 1)); rob = 6'($urandom); end
      we_exp = va[0] ? 2'b10 : 2'b01;
      @(negedge clk); bus.rsp_ready_i = 1'b0; drive_req(mode, va, rob); #1;
      total++;
      if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.req_ready_o); end
      sb.push_back('{rob: rob, vaddr: va, excp: 1'b0, ecode: 6'd0});
      @(negedge clk); bus.req_valid_i = 1'b0; #1;
      total++;
      if ({tag_we_o, tag_idx_o, busy_o, bus.rsp_valid_o} !== {we_exp, va[11:4], 1'b1, 1'b0}) begin
        bad++; $display("FAIL b2b_write[%0d]: we=%b idx=%h busy=%b rv=%b want we=%b idx=%h", i, tag_we_o, tag_idx_o, busy_o, bus.rsp_valid_o, we_exp, va[11:4]);
      end
      @(negedge clk); bus.rsp_ready_i = 1'b1; #1;
      e = sb.pop_front();
      total++;
      if ({bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o} !== {1'b1, e}) begin
        bad++; $display("FAIL b2b_rsp[%0d]: rv=%b rob=%h va=%h ex=%b ec=%h want rob=%h va=%h", i, bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, e.rob, e.vaddr);
      end
    end
    @(negedge clk); bus.rsp_ready_i = 1'b0;
  endtask

  // Mode 2 hit and miss: translation at +1, tag read at +2, write at +3, response at +4.
  task automatic test_mode2();
    logic [1:0] we_exp;
    for (int i = 0; i < 2; i++) begin
      trans_paddr_i = 32'h8000_1230;
      if (i == 0) begin tag_rdata_i = {1'b1, 20'h12345, 1'b1, 20'h80001}; we_exp = 2'b01; end
      else        begin tag_rdata_i = {1'b1, 20'h00001, 1'b0, 20'h80001}; we_exp = 2'b00; end
      @(negedge clk); drive_req(2'd2, 32'h0000_5230, 6'(20 + i)); #1;
      sb.push_back('{rob: 6'(20 + i), vaddr: 32'h0000_5230, excp: 1'b0, ecode: 6'd0});
      @(negedge clk); bus.req_valid_i = 1'b0; #1;
      total++;
      if ({trans_req_o, trans_vaddr_o, tag_rd_o, tag_we_o} !== {1'b1, 32'h0000_5230, 1'b0, 2'b00}) begin
        bad++; $display("FAIL m2_trans[%0d]: treq=%b tva=%h trd=%b twe=%b", i, trans_req_o, trans_vaddr_o, tag_rd_o, tag_we_o);
      end
      @(negedge clk); #1;
      total++;
      if ({trans_req_o, tag_rd_o, tag_we_o, tag_idx_o} !== {1'b0, 1'b1, 2'b00, 8'h23}) begin
        bad++; $display("FAIL m2_lookup[%0d]: treq=%b trd=%b twe=%b idx=%h want trd=1 idx=23", i, trans_req_o, tag_rd_o, tag_we_o, tag_idx_o);
      end
      @(negedge clk); #1;
      total++;
      if ({tag_rd_o, tag_we_o, bus.rsp_valid_o} !== {1'b0, we_exp, 1'b0}) begin
        bad++; $display("FAIL m2_write[%0d]: trd=%b twe=%b rv=%b want twe=%b", i, tag_rd_o, tag_we_o, bus.rsp_valid_o, we_exp);
      end
      @(negedge clk); bus.rsp_ready_i = 1'b1; #1;
      e = sb.pop_front();
      total++;
      if ({bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o} !== {1'b1, e}) begin
        bad++; $display("FAIL m2_rsp[%0d]: rv=%b rob=%h va=%h ex=%b ec=%h want rob=%h", i, bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, e.rob);
      end
      @(negedge clk); bus.rsp_ready_i = 1'b0;
    end
  endtask

  task automatic test_fault();
    trans_excp_i = 1'b1; trans_ecode_i = 6'h3;
    tag_rdata_i = {1'b1, 20'h00007, 1'b1, 20'h00007};
    trans_paddr_i = 32'h0000_7000;
    @(negedge clk); drive_req(2'd2, 32'h0000_7004, 6'd33); #1;
    sb.push_back('{rob: 6'd33, vaddr: 32'h0000_7004, excp: 1'b1, ecode: 6'h3});
    @(negedge clk); bus.req_valid_i = 1'b0; #1;
    @(negedge clk); #1;
    total++;
    if ({tag_rd_o, tag_we_o} !== 3'b000) begin bad++; $display("FAIL fault_lookup: trd=%b twe=%b want 0", tag_rd_o, tag_we_o); end
    @(negedge clk); bus.rsp_ready_i = 1'b1; #1;
    e = sb.pop_front();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, tag_we_o} !== {1'b1, e, 2'b00}) begin
      bad++; $display("FAIL fault_rsp: rv=%b rob=%h va=%h ex=%b ec=%h twe=%b want ex=1 ec=3 va=00007004", bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, tag_we_o);
    end
    @(negedge clk); bus.rsp_ready_i = 1'b0; trans_excp_i = 1'b0; trans_ecode_i = '0;
  endtask

  task automatic test_mode3_backpressure();
    @(negedge clk); drive_req(2'd3, 32'hDEAD_BEEF, 6'd9); #1;
    sb.push_back('{rob: 6'd9, vaddr: 32'hDEAD_BEEF, excp: 1'b0, ecode: 6'd0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_req(2'd0, 32'h0000_0100, 6'd44); bus.rsp_ready_i = 1'b0; #1;
      total++;
      if ({bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o, bus.req_ready_o, tag_we_o, tag_rd_o} !== {1'b1, sb[0], 1'b0, 2'b00, 1'b0}) begin
        bad++; $display("FAIL hold_rsp[%0d]: rv=%b rob=%h va=%h rdy=%b twe=%b trd=%b want rob=09 va=deadbeef rdy=0", i, bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.req_ready_o, tag_we_o, tag_rd_o);
      end
    end
    @(negedge clk); bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b1; #1;
    e = sb.pop_front();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o} !== {1'b1, e}) begin
      bad++; $display("FAIL hold_release: rv=%b rob=%h va=%h", bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o);
    end
    @(negedge clk); bus.rsp_ready_i = 1'b0; #1;
    total++;
    if ({busy_o, bus.req_ready_o, bus.rsp_valid_o} !== 3'b010) begin
      bad++; $display("FAIL hold_idle: busy=%b rdy=%b rv=%b want 0 1 0", busy_o, bus.req_ready_o, bus.rsp_valid_o);
    end
    @(negedge clk); #1;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL hold_no_accept: busy=%b want 0", busy_o); end
  endtask

  task automatic test_fetch_busy();
    fetch_busy_i = 1'b1;
    @(negedge clk); drive_req(2'd0, 32'h0000_0040, 6'd2); #1;
    sb.push_back('{rob: 6'd2, vaddr: 32'h0000_0040, excp: 1'b0, ecode: 6'd0});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); bus.req_valid_i = 1'b0;
      if (i == 5) fetch_busy_i = 1'b0;
      #1;
      total++;
      if ({busy_o, bus.req_ready_o, tag_we_o, tag_rd_o, trans_req_o, bus.rsp_valid_o} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL wait_fetch[%0d]: busy=%b rdy=%b twe=%b trd=%b treq=%b rv=%b", i, busy_o, bus.req_ready_o, tag_we_o, tag_rd_o, trans_req_o, bus.rsp_valid_o);
      end
    end
    @(negedge clk); #1;
    total++;
    if ({tag_we_o, tag_idx_o} !== {2'b01, 8'h04}) begin bad++; $display("FAIL wait_fetch_write: twe=%b idx=%h want 01 04", tag_we_o, tag_idx_o); end
    @(negedge clk); bus.rsp_ready_i = 1'b1; #1;
    e = sb.pop_front();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o, bus.rsp_excp_o, bus.rsp_ecode_o} !== {1'b1, e}) begin
      bad++; $display("FAIL wait_fetch_rsp: rv=%b rob=%h va=%h", bus.rsp_valid_o, bus.rsp_rob_idx_o, bus.rsp_vaddr_o);
    end
    @(negedge clk); bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk); drive_req(2'd1, 32'h0000_0011, 6'd7); #1;
    @(negedge clk); bus.req_valid_i = 1'b0; flush_i = 1'b1; #1;
    total++;
    if (tag_we_o !== 2'b00) begin bad++; $display("FAIL flush_write: twe=%b want 00", tag_we_o); end
    @(negedge clk); flush_i = 1'b0; #1;
    total++;
    if ({bus.rsp_valid_o, bus.req_ready_o, busy_o} !== 3'b010) begin
      bad++; $display("FAIL flush_idle: rv=%b rdy=%b busy=%b want 0 1 0", bus.rsp_valid_o, bus.req_ready_o, busy_o);
    end
    // Flush during LOOKUP suppresses the tag read.
    trans_paddr_i = 32'h8000_1230; tag_rdata_i = {1'b1, 20'h80001, 1'b1, 20'h80001};
    drive_req(2'd2, 32'h0000_1230, 6'd8);
    @(negedge clk); bus.req_valid_i = 1'b0;
    @(negedge clk); flush_i = 1'b1; #1;
    total++;
    if (tag_rd_o !== 1'b0) begin bad++; $display("FAIL flush_lookup: trd=%b want 0", tag_rd_o); end
    // A request coincident with flush is dropped.
    @(negedge clk); drive_req(2'd0, 32'h0000_0020, 6'd9); #1;
    @(negedge clk); bus.req_valid_i = 1'b0; flush_i = 1'b0; #1;
    total++;
    if ({busy_o, tag_we_o, bus.rsp_valid_o} !== 4'b0000) begin
      bad++; $display("FAIL flush_drop: busy=%b twe=%b rv=%b want all 0", busy_o, tag_we_o, bus.rsp_valid_o);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk); drive_req(2'd2, 32'h0000_1230, 6'd11); #1;
    @(negedge clk); bus.req_valid_i = 1'b0; #1;
    rst_n = 1'b0; #1;
    total++;
    if ({busy_o, trans_req_o, tag_rd_o, tag_we_o, bus.req_ready_o} !== {1'b0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      bad++; $display("FAIL reset_midop: busy=%b treq=%b trd=%b twe=%b rdy=%b", busy_o, trans_req_o, tag_rd_o, tag_we_o, bus.req_ready_o);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({busy_o, tag_rd_o, tag_we_o, bus.rsp_valid_o} !== 5'b00000) begin
        bad++; $display("FAIL reset_midop_after[%0d]: busy=%b trd=%b twe=%b rv=%b", i, busy_o, tag_rd_o, tag_we_o, bus.rsp_valid_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mode2();
    test_fault();
    test_mode3_backpressure();
    test_fetch_busy();
    test_flush();
    test_reset_midop();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
